// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared definitions for the countdown timer controller: state width and encodings.
package countdown_timer_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

endpackage

// File: rtl/countdown_timer_ctrl_tick_gen.sv
// Prescaler for the countdown timer: emits a one-cycle tick every prescale+1 enabled cycles.
module countdown_timer_ctrl_tick_gen #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] pre_r;
  logic                  tick_s;

  // Tick decode; >= keeps a lowered prescale from letting the phase wrap.
  always_comb begin
    tick_s = 1'b0;
    if (en && (pre_r >= prescale)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Prescaler phase register; held while disabled so a pause keeps the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r <= PRE_ZERO;
    end else if (clr) begin
      pre_r <= PRE_ZERO;
    end else if (en) begin
      pre_r <= tick_s ? PRE_ZERO : (pre_r + PRE_ONE);
    end else begin
      pre_r <= pre_r;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: sequences a WIDTH-bit down counter through load/run/pause/expire
// with one-shot or auto-reload behaviour and a registered one-cycle done pulse.
module countdown_timer_ctrl
  import countdown_timer_ctrl_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  done,
  output logic                  busy,
  output logic [STATE_W-1:0]    state
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_r;
  state_e           next_state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;
  logic             done_r;
  logic             tick_s;
  logic             en_s;
  logic             clr_s;
  logic             term_s;
  logic             rearm_ok_s;
  logic             busy_s;
  logic [WIDTH-1:0] eff_count_s;
  logic [WIDTH-1:0] eff_reload_s;

  countdown_timer_ctrl_tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (en_s),
    .clr      (clr_s),
    .prescale (prescale),
    .tick     (tick_s)
  );

  // Shared decode: same-cycle load counts as the effective value; stop overrides load and start.
  always_comb begin
    eff_count_s  = load ? load_val : count_r;
    eff_reload_s = load ? load_val : reload_r;
    en_s         = (state_r == ST_RUN) && !stop;
    term_s       = tick_s && (count_r == CNT_ONE);
    rearm_ok_s   = auto_reload && (reload_r != CNT_ZERO);
    clr_s        = 1'b0;
    if (!stop && start) begin
      if (state_r == ST_IDLE) begin
        clr_s = (eff_count_s != CNT_ZERO);
      end else if (state_r == ST_EXPIRED) begin
        clr_s = (eff_reload_s != CNT_ZERO);
      end else begin
        clr_s = 1'b0;
      end
    end else begin
      clr_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!stop && start && (eff_count_s != CNT_ZERO)) next_state_s = ST_RUN;
        else                                             next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop)                       next_state_s = ST_PAUSED;
        else if (term_s && !rearm_ok_s) next_state_s = ST_EXPIRED;
        else                            next_state_s = ST_RUN;
      end
      ST_PAUSED: begin
        if (stop)                                         next_state_s = ST_IDLE;
        else if (start && (eff_count_s != CNT_ZERO))      next_state_s = ST_RUN;
        else                                              next_state_s = ST_PAUSED;
      end
      ST_EXPIRED: begin
        if (stop)                                         next_state_s = ST_IDLE;
        else if (start && (eff_reload_s != CNT_ZERO))     next_state_s = ST_RUN;
        else                                              next_state_s = ST_EXPIRED;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    busy_s = 1'b0;
    if (state_r == ST_RUN) busy_s = 1'b1;
    else                   busy_s = 1'b0;
  end

  // Counter, reload register and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= CNT_ZERO;
      reload_r <= CNT_ZERO;
      done_r   <= 1'b0;
    end else begin
      done_r <= term_s;
      if (!stop && load) reload_r <= load_val;
      else               reload_r <= reload_r;
      case (state_r)
        ST_IDLE, ST_PAUSED: begin
          if (!stop && load) count_r <= load_val;
          else               count_r <= count_r;
        end
        ST_RUN: begin
          if (term_s)      count_r <= rearm_ok_s ? reload_r : CNT_ZERO;
          else if (tick_s) count_r <= count_r - CNT_ONE;
          else             count_r <= count_r;
        end
        ST_EXPIRED: begin
          if (clr_s)              count_r <= eff_reload_s;
          else if (!stop && load) count_r <= load_val;
          else                    count_r <= count_r;
        end
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign done  = done_r;
  assign busy  = busy_s;
  assign state = state_r;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: the driver queues hand-computed per-cycle
// expectations, a monitor pops and compares them just after each rising edge.
module tb_countdown_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [3:0] prescale;
  logic [3:0] count;
  logic       done;
  logic       busy;
  logic [1:0] state;

  typedef struct {
    logic [3:0] count;
    logic       done;
    logic [1:0] state;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  countdown_timer_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .prescale    (prescale),
    .count       (count),
    .done        (done),
    .busy        (busy),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic compare(input string nm, input logic [3:0] ec, input logic ed, input logic [1:0] es);
    logic eb;
    eb = (es == 2'd1);
    n_checks++;
    if (count !== ec || done !== ed || state !== es || busy !== eb) begin
      n_fail++;
      $display("FAIL %s: got count=%0d done=%0b busy=%0b state=%0d, expected count=%0d done=%0b busy=%0b state=%0d",
               nm, count, done, busy, state, ec, ed, eb, es);
    end
  endtask

  // Monitor: one expectation per clock edge, checked 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      compare(mon_e.name, mon_e.count, mon_e.done, mon_e.state);
    end
  end

  task automatic step(input logic ld, input logic [3:0] lv, input logic st, input logic sp,
                      input logic [3:0] ec, input logic ed, input logic [1:0] es, input string nm);
    exp_t e;
    @(negedge clk);
    load = ld; load_val = lv; start = st; stop = sp;
    @(posedge clk);
    e.count = ec; e.done = ed; e.state = es; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] ec, input logic ed, input logic [1:0] es, input string nm);
    step(1'b0, 4'd0, 1'b0, 1'b0, ec, ed, es, nm);
  endtask

  task automatic set_mode(input logic [3:0] ps, input logic ar);
    @(negedge clk);
    load = 1'b0; start = 1'b0; stop = 1'b0; load_val = 4'd0;
    prescale = ps; auto_reload = ar;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = 4'd0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; prescale = 4'd0;
    repeat (2) @(negedge clk);
    compare("reset_state", 4'd0, 1'b0, 2'd0);
    rst = 1'b0;

    // One-shot, prescale 0.
    step(1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 2'd0, "t1_load");
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 2'd1, "t1_start");
    idle(4'd2, 1'b0, 2'd1, "t1_run2");
    idle(4'd1, 1'b0, 2'd1, "t1_run1");
    idle(4'd0, 1'b1, 2'd3, "t1_done");
    idle(4'd0, 1'b0, 2'd3, "t1_expired_hold");
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 2'd0, "t1_stop_idle");

    // Prescale 2: three cycles per count.
    set_mode(4'd2, 1'b0);
    step(1'b1, 4'd2, 1'b0, 1'b0, 4'd2, 1'b0, 2'd0, "t2_load");
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 2'd1, "t2_start");
    for (int i = 0; i < 2; i++) idle(4'd2, 1'b0, 2'd1, "t2_hold2");
    for (int i = 0; i < 3; i++) idle(4'd1, 1'b0, 2'd1, "t2_hold1");
    idle(4'd0, 1'b1, 2'd3, "t2_done");
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 2'd0, "t2_stop_idle");

    // Auto-reload, period 4.
    set_mode(4'd0, 1'b1);
    step(1'b1, 4'd4, 1'b0, 1'b0, 4'd4, 1'b0, 2'd0, "t3_load");
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 2'd1, "t3_start");
    for (int p = 0; p < 2; p++) begin
      idle(4'd3, 1'b0, 2'd1, "t3_run3");
      idle(4'd2, 1'b0, 2'd1, "t3_run2");
      idle(4'd1, 1'b0, 2'd1, "t3_run1");
      idle(4'd4, 1'b1, 2'd1, "t3_reload_done");
    end
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 2'd2, "t3_pause");
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 2'd0, "t3_abort_idle");

    // Pause and resume.
    set_mode(4'd0, 1'b0);
    step(1'b1, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 2'd0, "t4_load");
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd9, 1'b0, 2'd1, "t4_start");
    idle(4'd8, 1'b0, 2'd1, "t4_run8");
    idle(4'd7, 1'b0, 2'd1, "t4_run7");
    idle(4'd6, 1'b0, 2'd1, "t4_run6");
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0, 2'd2, "t4_pause");
    for (int i = 0; i < 5; i++) idle(4'd6, 1'b0, 2'd2, "t4_paused_hold");
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 1'b0, 2'd1, "t4_resume");
    idle(4'd5, 1'b0, 2'd1, "t4_run5");
    idle(4'd4, 1'b0, 2'd1, "t4_run4");
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 2'd2, "t4_pause2");
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 2'd0, "t4_abort_idle");

    // Load during RUN only touches reload; re-arm from EXPIRED uses it.
    step(1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 1'b0, 2'd0, "t5_load");
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 2'd1, "t5_start");
    idle(4'd4, 1'b0, 2'd1, "t5_run4");
    idle(4'd3, 1'b0, 2'd1, "t5_run3");
    step(1'b1, 4'd7, 1'b0, 1'b0, 4'd2, 1'b0, 2'd1, "t5_load_in_run");
    idle(4'd1, 1'b0, 2'd1, "t5_run1");
    idle(4'd0, 1'b1, 2'd3, "t5_done");
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 1'b0, 2'd1, "t5_rearm");
    idle(4'd6, 1'b0, 2'd1, "t5_run6");
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0, 2'd2, "t5_pause");
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0, 2'd0, "t5_abort_idle");

    // Asynchronous reset mid-run, then start ignored and stop-over-start priority.
    step(1'b1, 4'd8, 1'b0, 1'b0, 4'd8, 1'b0, 2'd0, "t6_load");
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd8, 1'b0, 2'd1, "t6_start");
    idle(4'd7, 1'b0, 2'd1, "t6_run7");
    idle(4'd6, 1'b0, 2'd1, "t6_run6");
    idle(4'd5, 1'b0, 2'd1, "t6_run5");
    #3;
    rst = 1'b1;
    #1;
    compare("t6_async_rst", 4'd0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, "t6_start_ignored");
    idle(4'd0, 1'b0, 2'd0, "t6_idle_hold");
    step(1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 2'd0, "t6_load3");
    step(1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 2'd0, "t6_stop_beats_start");
    idle(4'd3, 1'b0, 2'd0, "t6_idle_after");

    @(negedge clk);
    load = 1'b0; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sb_q.size() > 0) @(posedge clk);
    end
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
